// File: rtl/hp_fifo.sv
// Dual-clock host-to-parasite FIFO. Both domains act on the falling edge of their own phi2.
// Pointers are Gray-coded and cross domains through two-stage synchronisers.
module hp_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             h_rst_b,
    input  logic             h_phi2,
    input  logic             p_phi2,
    input  logic             h_we_b,
    input  logic             h_selectData,
    input  logic [WIDTH-1:0] h_data,
    input  logic             h_single,
    input  logic             p_selectData,
    input  logic             p_rdnw,
    output logic [WIDTH-1:0] p_data,
    output logic             p_data_available,
    output logic             h_full,
    output logic             h_overrun,
    output logic [AW:0]      h_count
);

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Host-domain state
    logic [AW:0] wbin_q, wbin_d;
    logic [AW:0] wgray_q, wgray_d;
    logic [AW:0] rgray_s1_q, rgray_s2_q;
    logic        overrun_q, overrun_d;
    logic [AW:0] rbin_sync;
    logic        h_wr_req, h_wr_en;

    // Parasite-domain state
    logic [AW:0] rbin_q, rbin_d;
    logic [AW:0] rgray_q, rgray_d;
    logic [AW:0] wgray_s1_q, wgray_s2_q;
    logic        p_rd_en;

    // ---------------- host side ----------------
    assign h_wr_req  = h_selectData && !h_we_b;
    assign h_wr_en   = h_wr_req && !h_full;
    assign rbin_sync = gray2bin(rgray_s2_q);
    assign h_count   = wbin_q - rbin_sync;
    assign h_full    = h_single ? (h_count != '0) : (h_count == (AW+1)'(DEPTH));
    assign h_overrun = overrun_q;

    always_comb begin
        wbin_d    = wbin_q;
        wgray_d   = wgray_q;
        overrun_d = overrun_q;
        if (h_wr_en) begin
            wbin_d  = wbin_q + (AW+1)'(1);
            wgray_d = bin2gray(wbin_q + (AW+1)'(1));
        end
        if (h_wr_req && h_full) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(negedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            rgray_s1_q <= '0;
            rgray_s2_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            rgray_s1_q <= rgray_q;
            rgray_s2_q <= rgray_s1_q;
            overrun_q  <= overrun_d;
        end
    end

    // Storage is cleared by reset so p_data reads zero while held in reset.
    always_ff @(negedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (h_wr_en) begin
            mem_q[wbin_q[AW-1:0]] <= h_data;
        end
    end

    // ---------------- parasite side ----------------
    // Gray equality is equivalent to binary equality, so no decode is needed here.
    assign p_data_available = (wgray_s2_q != rgray_q);
    assign p_rd_en          = p_selectData && p_rdnw && p_data_available;
    assign p_data           = mem_q[rbin_q[AW-1:0]];

    always_comb begin
        rbin_d  = rbin_q;
        rgray_d = rgray_q;
        if (p_rd_en) begin
            rbin_d  = rbin_q + (AW+1)'(1);
            rgray_d = bin2gray(rbin_q + (AW+1)'(1));
        end
    end

    always_ff @(negedge p_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            rbin_q     <= '0;
            rgray_q    <= '0;
            wgray_s1_q <= '0;
            wgray_s2_q <= '0;
        end else begin
            rbin_q     <= rbin_d;
            rgray_q    <= rgray_d;
            wgray_s1_q <= wgray_q;
            wgray_s2_q <= wgray_s1_q;
        end
    end

endmodule

// File: tb/tb_hp_fifo.sv
// Self-checking bench for hp_fifo: directed scenarios plus randomized two-clock traffic
// checked against a queue model of the FIFO contents.
`timescale 1ns/1ps
module tb_hp_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int AW    = $clog2(DEPTH);

    logic             h_rst_b;
    logic             h_phi2;
    logic             p_phi2;
    logic             h_we_b;
    logic             h_selectData;
    logic [WIDTH-1:0] h_data;
    logic             h_single;
    logic             p_selectData;
    logic             p_rdnw;
    logic [WIDTH-1:0] p_data;
    logic             p_data_available;
    logic             h_full;
    logic             h_overrun;
    logic [AW:0]      h_count;

    hp_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .h_rst_b         (h_rst_b),
        .h_phi2          (h_phi2),
        .p_phi2          (p_phi2),
        .h_we_b          (h_we_b),
        .h_selectData    (h_selectData),
        .h_data          (h_data),
        .h_single        (h_single),
        .p_selectData    (p_selectData),
        .p_rdnw          (p_rdnw),
        .p_data          (p_data),
        .p_data_available(p_data_available),
        .h_full          (h_full),
        .h_overrun       (h_overrun),
        .h_count         (h_count)
    );

    int h_half = 10;
    int p_half = 10;

    initial begin
        h_phi2 = 1'b0;
        forever #(h_half) h_phi2 = ~h_phi2;
    end

    initial begin
        p_phi2 = 1'b0;
        #3;
        forever #(p_half) p_phi2 = ~p_phi2;
    end

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] model_q [$];
    bit               model_ovr;
    int               rx_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_h(input int n);
        repeat (n) @(posedge h_phi2);
    endtask

    task automatic wait_p(input int n);
        repeat (n) @(posedge p_phi2);
    endtask

    task automatic do_reset();
        h_rst_b = 1'b0;
        #25;
        @(posedge h_phi2);
        h_rst_b = 1'b1;
        model_q.delete();
        model_ovr = 1'b0;
        #1;
    endtask

    // One host write: strobe driven on the rising edge, captured on the following falling edge.
    task automatic host_write(input logic [WIDTH-1:0] d);
        @(posedge h_phi2);
        h_selectData = 1'b1;
        h_we_b       = 1'b0;
        h_data       = d;
        @(posedge h_phi2);
        h_selectData = 1'b0;
        h_we_b       = 1'b1;
    endtask

    task automatic p_read();
        @(posedge p_phi2);
        p_selectData = 1'b1;
        @(posedge p_phi2);
        p_selectData = 1'b0;
    endtask

    // Random traffic: host pushes into the model when it sees room, parasite pops when it sees data.
    task automatic run_traffic(input int n_wr, input int wr_pct, input int rd_pct,
                               input bit seq, input bit allow_ovr);
        bit host_done;
        host_done = 1'b0;
        rx_count  = 0;
        fork
            begin
                int sent = 0;
                int eff;
                logic [WIDTH-1:0] dat;
                eff = h_single ? 1 : DEPTH;
                while (sent < n_wr) begin
                    @(posedge h_phi2);
                    chk("ovr_sticky", {31'd0, h_overrun}, {31'd0, model_ovr});
                    chk("hcount_ge_occ", {31'd0, (int'(h_count) >= model_q.size())}, 32'd1);
                    chk("hcount_le_depth", {31'd0, (int'(h_count) <= eff)}, 32'd1);
                    h_selectData = 1'b0;
                    h_we_b       = 1'b1;
                    if ($urandom_range(99) < wr_pct) begin
                        dat = seq ? WIDTH'(sent) : WIDTH'($urandom);
                        if (!h_full) begin
                            h_selectData = 1'b1;
                            h_we_b       = 1'b0;
                            h_data       = dat;
                            model_q.push_back(dat);
                            sent++;
                        end else if (allow_ovr && $urandom_range(99) < 5) begin
                            h_selectData = 1'b1;
                            h_we_b       = 1'b0;
                            h_data       = dat;
                            model_ovr    = 1'b1;
                        end
                    end
                end
                @(posedge h_phi2);
                h_selectData = 1'b0;
                h_we_b       = 1'b1;
                host_done    = 1'b1;
            end
            begin
                int guard = 0;
                while (!(host_done && model_q.size() == 0) && guard < 5000) begin
                    @(posedge p_phi2);
                    guard++;
                    p_selectData = 1'b0;
                    if ($urandom_range(99) < rd_pct) begin
                        p_selectData = 1'b1;
                        if (p_data_available) begin
                            if (model_q.size() == 0) begin
                                chk("avail_when_empty", 32'd1, 32'd0);
                            end else begin
                                chk("rd_data", {24'd0, p_data}, {24'd0, model_q[0]});
                                void'(model_q.pop_front());
                                rx_count++;
                            end
                        end
                    end
                end
                @(posedge p_phi2);
                p_selectData = 1'b0;
                chk("drain_in_budget", {31'd0, (guard < 5000)}, 32'd1);
            end
        join
        chk("rx_total", rx_count, n_wr);
        wait_p(4);
        wait_h(4);
        chk("drained_avail", {31'd0, p_data_available}, 32'd0);
        chk("drained_count", {31'd0, h_count}, 32'd0);
    endtask

    initial begin
        h_rst_b      = 1'b0;
        h_we_b       = 1'b1;
        h_selectData = 1'b0;
        h_data       = '0;
        h_single     = 1'b0;
        p_selectData = 1'b0;
        p_rdnw       = 1'b1;
        model_ovr    = 1'b0;
        rx_count     = 0;

        // Outputs while held in reset
        #7;
        chk("rst_avail", {31'd0, p_data_available}, 32'd0);
        chk("rst_full", {31'd0, h_full}, 32'd0);
        chk("rst_count", {31'd0, h_count}, 32'd0);
        chk("rst_pdata", {24'd0, p_data}, 32'd0);
        chk("rst_ovr", {31'd0, h_overrun}, 32'd0);
        do_reset();

        // Fill to full depth, drain in order
        host_write(8'h11);
        host_write(8'h22);
        chk("fill_full", {31'd0, h_full}, 32'd1);
        chk("fill_count", {31'd0, h_count}, 32'd2);
        wait_p(4);
        chk("fill_avail", {31'd0, p_data_available}, 32'd1);
        chk("fill_head0", {24'd0, p_data}, 32'h11);
        p_read();
        chk("fill_head1", {24'd0, p_data}, 32'h22);
        chk("fill_avail1", {31'd0, p_data_available}, 32'd1);
        p_read();
        chk("fill_empty", {31'd0, p_data_available}, 32'd0);
        wait_h(4);
        chk("fill_count0", {31'd0, h_count}, 32'd0);
        chk("fill_notfull", {31'd0, h_full}, 32'd0);

        // Read while empty must not move the read pointer
        p_read();
        p_read();
        wait_p(1);
        chk("empty_rd_avail", {31'd0, p_data_available}, 32'd0);
        host_write(8'h33);
        wait_p(4);
        chk("empty_rd_head", {24'd0, p_data}, 32'h33);
        p_read();
        wait_p(1);
        chk("empty_rd_drain", {31'd0, p_data_available}, 32'd0);
        wait_h(4);

        // Single-entry mode with overrun
        h_single = 1'b1;
        host_write(8'hA5);
        chk("single_full", {31'd0, h_full}, 32'd1);
        chk("single_noovr", {31'd0, h_overrun}, 32'd0);
        host_write(8'h5A);
        chk("single_ovr", {31'd0, h_overrun}, 32'd1);
        chk("single_count", {31'd0, h_count}, 32'd1);
        wait_p(4);
        chk("single_head", {24'd0, p_data}, 32'hA5);
        p_read();
        wait_p(1);
        chk("single_empty", {31'd0, p_data_available}, 32'd0);
        wait_h(4);
        chk("single_free", {31'd0, h_full}, 32'd0);
        h_single = 1'b0;
        do_reset();

        // Concurrent write and read with one entry held
        host_write(8'h44);
        wait_p(4);
        fork
            host_write(8'h55);
            p_read();
        join
        wait_p(4);
        wait_h(4);
        chk("conc_count", {31'd0, h_count}, 32'd1);
        chk("conc_head", {24'd0, p_data}, 32'h55);
        p_read();
        wait_h(4);
        chk("conc_drain", {31'd0, h_count}, 32'd0);

        // Randomized traffic, full depth, then sequential wrap at both clock ratios
        run_traffic(200, 60, 50, 1'b0, 1'b0);
        h_half = 15;
        p_half = 5;
        run_traffic(10, 100, 100, 1'b1, 1'b0);
        h_half = 5;
        p_half = 15;
        run_traffic(10, 100, 100, 1'b1, 1'b0);
        h_half = 10;
        p_half = 10;
        wait_h(2);

        // Single-entry mode under random traffic, overrun attempts allowed
        h_single = 1'b1;
        run_traffic(60, 70, 40, 1'b0, 1'b1);
        h_single = 1'b0;
        do_reset();

        // Asynchronous reset with two entries held
        host_write(8'h66);
        host_write(8'h77);
        wait_p(4);
        chk("mid_avail_pre", {31'd0, p_data_available}, 32'd1);
        #3;
        h_rst_b = 1'b0;
        #1;
        chk("mid_avail", {31'd0, p_data_available}, 32'd0);
        chk("mid_full", {31'd0, h_full}, 32'd0);
        chk("mid_count", {31'd0, h_count}, 32'd0);
        chk("mid_pdata", {24'd0, p_data}, 32'd0);
        @(posedge h_phi2);
        h_rst_b = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hp_fifo.md
HP_FIFO -- requirements
Module: hp_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits of each entry.
REQ-002 Parameter DEPTH, default 2, entry count; SHALL be a power of two, >= 2; AW = log2(DEPTH).
REQ-003 h_rst_b  input  1  reset h_rst_b, asynchronous, active-low; resets both host-side and parasite-side state.
REQ-004 h_phi2  input  1  host clock; host-side state updates on its falling edge.
REQ-005 p_phi2  input  1  parasite clock; parasite-side state updates on its falling edge; asynchronous to h_phi2.
REQ-006 h_we_b  input  1  host write strobe, active-low.
REQ-007 h_selectData  input  1  host selects this FIFO's data register.
REQ-008 h_data  input  WIDTH  host write data.
REQ-009 h_single  input  1  1 = one-entry mode (effective depth 1), 0 = full DEPTH; quasi-static, changed only while FIFO empty.
REQ-010 p_selectData  input  1  parasite selects this FIFO's data register.
REQ-011 p_rdnw  input  1  parasite read/not-write; 1 = read.
REQ-012 p_data  output  WIDTH  head-of-FIFO entry.
REQ-013 p_data_available  output  1  at least one entry visible to parasite.
REQ-014 h_full  output  1  host must not write; effective depth reached.
REQ-015 h_overrun  output  1  sticky; a host write was attempted while h_full.
REQ-016 h_count  output  AW+1  entries occupied, as seen by host domain.

Function
REQ-017 Host write: at falling h_phi2 with h_selectData=1, h_we_b=0, h_full=0 -> store h_data at write pointer, increment write pointer (AW+1 bits, wraps modulo 2*DEPTH).
REQ-018 Host write while h_full=1: storage and pointer unchanged; h_overrun set at same edge.
REQ-019 Parasite read: at falling p_phi2 with p_selectData=1, p_rdnw=1, p_data_available=1 -> increment read pointer (AW+1 bits, wraps).
REQ-020 Parasite read while p_data_available=0: no state change (no underflow).
REQ-021 p_data SHALL be combinational from storage at read pointer's low AW bits; stable whenever p_data_available=1.
REQ-022 Pointers crossing domains SHALL be Gray-coded and passed through a 2-stage synchroniser clocked by the destination domain falling edge.
REQ-023 p_data_available = (synchronised write pointer != read pointer).
REQ-024 h_count = write pointer - synchronised read pointer (binary, modulo 2*DEPTH).
REQ-025 h_full = 1 when h_count >= 1 with h_single=1, or h_count == DEPTH with h_single=0.
REQ-026 Latency: write -> p_data_available=1 after at most 3 falling p_phi2 edges; read -> h_full deasserted after at most 3 falling h_phi2 edges.
REQ-027 Flags SHALL be conservative: p_data_available never asserted for an unwritten entry; h_full never deasserted before the slot is read.
REQ-028 Simultaneous host write and parasite read in same period: both take effect; no entry lost or duplicated.
REQ-029 Pointer wrap: sequence continues correctly across the 2*DEPTH boundary, data order preserved.
REQ-030 Storage SHALL be written only in the host domain; no storage reset required beyond REQ-031.

Reset
REQ-031 While h_rst_b=0: both pointers, all synchroniser stages, h_overrun = 0; storage = 0; hence p_data = 0, p_data_available = 0, h_full = 0, h_count = 0.
REQ-032 Reset asserted mid-transfer: pending entries discarded immediately, outputs at REQ-031 values without clock edges.

Verification
REQ-033 Reset, h_single=0, DEPTH=2: host writes 0x11, 0x22 -> h_full=1, h_count=2; parasite reads -> p_data 0x11 then 0x22, p_data_available=0 after second read.
REQ-034 h_single=1: write 0xA5 -> h_full=1 within 1 host edge; second write 0x5A ignored, h_overrun=1; parasite reads 0xA5.
REQ-035 Read when empty: p_selectData=1, p_rdnw=1, no writes -> read pointer unchanged, p_data_available stays 0.
REQ-036 Wrap: 10 write/read pairs of 0x00..0x09 with p_phi2:h_phi2 ratio 3:1 and 1:3 -> all values received in order, none duplicated.
REQ-037 Concurrent: FIFO holding 1 entry, write and read in same period -> h_count returns to 1, order preserved.
REQ-038 Reset asserted with 2 entries held -> p_data_available=0, h_full=0, h_count=0, p_data=0 immediately.
